afifo_write_arbiter: RTL and testbench

AFIFO_WRITE_ARBITER -- requirements
Module: afifo_write_arbiter

---
 rtl/afifo_arb_pkg.sv | 7 +
 rtl/afifo_write_arbiter_if.sv | 16 +
 rtl/afifo_write_arbiter_rr_pick.sv | 22 ++
 rtl/afifo_write_arbiter.sv | 71 +++++++
 tb/tb_afifo_write_arbiter.sv | 148 ++++++++++++++
 5 files changed

// File: rtl/afifo_arb_pkg.sv
// afifo_arb_pkg: shared state encoding and default sizing for the FIFO write arbiter.
package afifo_arb_pkg;
    typedef enum logic {IDLE, BURST} state_e;
    localparam int DEF_DATA_SIZE = 3;
    localparam int DEF_NUM_REQ   = 4;
    localparam int DEF_MAX_BURST = 4;
endpackage

// File: rtl/afifo_write_arbiter_if.sv
// afifo_write_arbiter_if: requester/FIFO-side signals of the write arbiter.
interface afifo_write_arbiter_if #(
    parameter int DataSize = 3,
    parameter int NumReq   = 4
);
    logic [NumReq-1:0]          Req;
    logic [NumReq*DataSize-1:0] ReqData;
    logic                       full;
    logic [NumReq-1:0]          Gnt;
    logic                       Push;
    logic [DataSize-1:0]        DataIn;
    logic [$clog2(NumReq)-1:0]  Owner;
    logic                       Busy;
    modport slave  (input Req, ReqData, full, output Gnt, Push, DataIn, Owner, Busy);
    modport master (output Req, ReqData, full, input Gnt, Push, DataIn, Owner, Busy);
endinterface

// File: rtl/afifo_write_arbiter_rr_pick.sv
// rr_pick: first requester found scanning round-robin from LastOwner+1.
module rr_pick #(
    parameter int NumReq = 4
) (
    input  logic [NumReq-1:0]         Req,
    input  logic [$clog2(NumReq)-1:0] LastOwner,
    output logic                      Valid,
    output logic [$clog2(NumReq)-1:0] Index
);
    localparam int IW = $clog2(NumReq);
    logic [IW-1:0] j;
    assign Valid = |Req;
    // scan furthest-first so the nearest requester after LastOwner wins
    always_comb begin
        Index = '0;
        j = '0;
        for (int k = NumReq; k >= 1; k--) begin
            j = IW'((int'(LastOwner) + k) % NumReq);
            if (Req[j]) Index = j;
        end
    end
endmodule

// File: rtl/afifo_write_arbiter.sv
// afifo_write_arbiter: round-robin burst arbiter feeding one FIFO write port.
module afifo_write_arbiter
    import afifo_arb_pkg::*;
#(
    parameter int DataSize = DEF_DATA_SIZE,
    parameter int NumReq   = DEF_NUM_REQ,
    parameter int MaxBurst = DEF_MAX_BURST
) (
    input logic                  Wclk,
    input logic                  Wresetn,
    afifo_write_arbiter_if.slave bus
);
    localparam int OW = $clog2(NumReq);
    localparam int CW = $clog2(MaxBurst + 1);
    state_e        state_q, state_d;
    logic [OW-1:0] owner_q, owner_d, last_q, last_d, pick_idx;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pick_valid, own_req, xfer;
    rr_pick #(.NumReq(NumReq)) u_pick (
        .Req       (bus.Req),
        .LastOwner (last_q),
        .Valid     (pick_valid),
        .Index     (pick_idx)
    );
    assign own_req = bus.Req[owner_q];
    // reset gates the transfer so nothing leaks out in a reset cycle
    assign xfer = Wresetn && state_q == BURST && own_req && !bus.full;
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        if (state_q == IDLE) begin
            if (pick_valid && !bus.full) begin
                state_d = BURST;
                owner_d = pick_idx;
                cnt_d   = '0;
            end
        end else if (!own_req) begin
            state_d = IDLE;
            last_d  = owner_q;
        end else if (xfer) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_d == CW'(MaxBurst)) begin
                state_d = IDLE;
                last_d  = owner_q;
            end
        end
    end
    always_ff @(posedge Wclk) begin
        if (!Wresetn) begin
            state_q <= IDLE;
            owner_q <= '0;
            cnt_q   <= '0;
            last_q  <= OW'(NumReq - 1);
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
        end
    end
    always_comb begin
        bus.Gnt          = '0;
        bus.Gnt[owner_q] = xfer;
        bus.Push         = xfer;
        bus.DataIn       = xfer ? bus.ReqData[owner_q*DataSize +: DataSize] : '0;
        bus.Owner        = owner_q;
        bus.Busy         = state_q == BURST;
    end
endmodule

// File: tb/tb_afifo_write_arbiter.sv
// tb_afifo_write_arbiter: directed scenarios plus random traffic against a burst-level model.
module tb_afifo_write_arbiter;
    localparam int DS = 3;
    localparam int NR = 4;
    localparam int MB = 4;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_bad = 0;
    always #5 clk = ~clk;
    afifo_write_arbiter_if #(.DataSize(DS), .NumReq(NR)) bus ();
    afifo_write_arbiter #(.DataSize(DS), .NumReq(NR), .MaxBurst(MB)) dut (
        .Wclk    (clk),
        .Wresetn (rst_n),
        .bus     (bus)
    );
    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic apply_reset(input int n);
        rst_n = 1'b0;
        repeat (n) tick();
        rst_n = 1'b1;
    endtask
    // burst-level model: who owns the port, how many words it has moved, who went last
    bit m_busy = 1'b0;
    int m_owner = 0;
    int m_last = NR - 1;
    int m_words = 0;
    initial begin
        logic [NR-1:0] eg;
        int ed;
        @(posedge clk);
        forever begin
            @(negedge clk);
            eg = '0;
            if (rst_n && m_busy && bus.Req[m_owner] && !bus.full) eg[m_owner] = 1'b1;
            ed = (eg != 0) ? int'(bus.ReqData[m_owner*DS +: DS]) : 0;
            chk("gnt", int'(bus.Gnt), int'(eg));
            chk("push", int'(bus.Push), int'(eg != 0));
            chk("data", int'(bus.DataIn), ed);
            chk("busy", int'(bus.Busy), int'(m_busy));
            chk("owner", int'(bus.Owner), m_owner);
            chk("push_while_full", int'(bus.Push && bus.full), 0);
            chk("gnt_onehot0", int'($countones(bus.Gnt) <= 1), 1);
            if (!rst_n) begin
                m_busy = 1'b0; m_owner = 0; m_words = 0; m_last = NR - 1;
            end else if (!m_busy) begin
                if (bus.Req != 0 && !bus.full) begin
                    for (int k = NR; k >= 1; k--)
                        if (bus.Req[(m_last + k) % NR]) m_owner = (m_last + k) % NR;
                    m_words = 0;
                    m_busy = 1'b1;
                end
            end else if (!bus.Req[m_owner]) begin
                m_busy = 1'b0; m_last = m_owner;
            end else if (!bus.full) begin
                m_words++;
                if (m_words == MB) begin
                    m_busy = 1'b0; m_last = m_owner;
                end
            end
        end
    end
    initial begin
        int bl_exp[12] = '{-1, 0, 0, 0, 0, -1, 1, 1, 1, 1, -1, 0};
        int fs_push[11] = '{0, 1, 1, 0, 0, 0, 0, 0, 1, 1, 0};
        int fs_busy[11] = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
        bus.Req = '0; bus.ReqData = '0; bus.full = 1'b0;
        // reset hold with everyone requesting
        bus.Req = 4'b1111;
        rst_n = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick(); #2;
            chk("rst_gnt", int'(bus.Gnt), 0);
            chk("rst_push", int'(bus.Push), 0);
            chk("rst_busy", int'(bus.Busy), 0);
        end
        tick(); rst_n = 1'b1; #2;
        chk("rel_busy", int'(bus.Busy), 0);
        tick(); #2;
        chk("rel_busy2", int'(bus.Busy), 1);
        chk("rel_owner", int'(bus.Owner), 0);
        // burst limit: two requesters alternate in bursts of MB
        tick(); bus.Req = 4'b0011; bus.ReqData = $urandom;
        apply_reset(2);
        for (int c = 0; c < 12; c++) begin
            #2; chk("burst_seq", bus.Push ? int'(bus.Owner) : -1, bl_exp[c]);
            tick();
        end
        // full stall after the second word
        bus.Req = 4'b0001;
        apply_reset(2);
        for (int c = 0; c < 11; c++) begin
            bus.full = (c >= 3 && c <= 7);
            #2;
            chk("stall_push", int'(bus.Push), fs_push[c]);
            chk("stall_busy", int'(bus.Busy), fs_busy[c]);
            tick();
        end
        bus.full = 1'b0;
        // release: requester 2 drops after one word, 3 takes over
        bus.Req = 4'b1100; bus.ReqData = {3'd6, 3'd5, 3'd3, 3'd1};
        apply_reset(2);
        tick(); #2;
        chk("rls_owner", int'(bus.Owner), 2);
        chk("rls_data", int'(bus.DataIn), 5);
        tick(); bus.Req = 4'b1000; #2;
        chk("rls_drop_push", int'(bus.Push), 0);
        chk("rls_drop_data", int'(bus.DataIn), 0);
        tick(); #2;
        chk("rls_idle", int'(bus.Busy), 0);
        tick(); #2;
        chk("rls_next_owner", int'(bus.Owner), 3);
        chk("rls_next_data", int'(bus.DataIn), 6);
        // reset on the third word of a burst
        bus.Req = 4'b0010;
        apply_reset(2);
        tick(); tick(); #2;
        chk("mrst_word2", int'(bus.Push), 1);
        tick(); rst_n = 1'b0; bus.Req = 4'b1111; #2;
        chk("mrst_push", int'(bus.Push), 0);
        tick(); rst_n = 1'b1; #2;
        chk("mrst_idle", int'(bus.Busy), 0);
        tick(); #2;
        chk("mrst_owner", int'(bus.Owner), 0);
        chk("mrst_push2", int'(bus.Push), 1);
        // random traffic
        for (int c = 0; c < 3000; c++) begin
            tick();
            for (int i = 0; i < NR; i++) bus.Req[i] = ($urandom_range(0, 3) != 0);
            bus.ReqData = $urandom;
            bus.full = ($urandom_range(0, 3) == 0);
            rst_n = ($urandom_range(0, 99) != 0);
        end
        tick(); tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
